seq_alu: RTL and testbench

- Parametrised successor to the EX-stage combinational ALU: registered single-cycle base ops plus iterative multi-cycle multiply/divide (RV32M-style).
- Sits in EX; valid/ready handshake on both sides so the pipeline stalls while a mul/div is in flight; flush input aborts on branch/exception.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/seq_alu_if.sv | 28 ++
 rtl/muldiv_iter.sv | 131 +++++++++++++
 rtl/seq_alu.sv | 106 ++++++++++
 tb/tb_seq_alu.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   - 5-bit opcode constants (base ops and the multiply/divide group)
//   - FSM state type used by the top level
//   - small decode helpers for the multiply/divide group
package alu_pkg;

  localparam logic [4:0] OP_AND    = 5'b00000;
  localparam logic [4:0] OP_OR     = 5'b00001;
  localparam logic [4:0] OP_ADD    = 5'b00010;
  localparam logic [4:0] OP_SUB    = 5'b00110;
  localparam logic [4:0] OP_SLT    = 5'b00111;
  localparam logic [4:0] OP_SLTU   = 5'b01001;
  localparam logic [4:0] OP_XOR    = 5'b01100;
  localparam logic [4:0] OP_SRL    = 5'b01101;
  localparam logic [4:0] OP_SLL    = 5'b01110;
  localparam logic [4:0] OP_SRA    = 5'b01111;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  // The whole 10xxx block is multiply/divide; bit 2 separates div/rem from mul.
  function automatic logic is_muldiv(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

  function automatic logic is_divop(input logic [4:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Handshake/data bundle between the EX-stage issue logic and seq_alu.
//   master: drives flush, in_valid, op, a, b, out_ready
//   slave : drives in_ready, out_valid, res, zero, busy
interface seq_alu_if #(
  parameter int WIDTH = 32
) ();
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             zero;
  logic             busy;

  modport master (
    output flush, in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, res, zero, busy
  );

  modport slave (
    input  flush, in_valid, op, a, b, out_ready,
    output in_ready, out_valid, res, zero, busy
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine, one bit per clock.
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : abort the operation in flight
//   start      : latch op/a/b and begin (one-cycle pulse)
//   op         : 10xxx opcode (mul, mulh, mulhsu, mulhu, div, divu, rem, remu)
//   a, b       : operands, only sampled on start
//   done       : high for the cycle in which result is final
//   result     : sign-corrected result, valid while done
// Operands are converted to magnitudes at start; after WIDTH steps the sign
// is re-applied, so both algorithms only ever see unsigned numbers.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH) + 1;

  // mul: acc = {partial high, remaining multiplier bits}
  // div: acc = {partial remainder, dividend bits being replaced by quotient}
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   m_reg;      // multiplicand or divisor magnitude
  logic [CW-1:0]      cnt_reg;
  logic               active_reg;
  logic               div_reg;
  logic               neg_reg;    // negate the selected result at the end
  logic               hi_reg;     // mul: upper half; div: remainder
  logic               dz_reg;     // divide by zero

  logic             a_signed, b_signed, start_hi;
  logic             sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    start_hi = 1'b0;
    case (op)
      OP_MUL:    ;
      OP_MULH:   begin a_signed = 1'b1; b_signed = 1'b1; start_hi = 1'b1; end
      OP_MULHSU: begin a_signed = 1'b1; start_hi = 1'b1; end
      OP_MULHU:  start_hi = 1'b1;
      OP_DIV:    begin a_signed = 1'b1; b_signed = 1'b1; end
      OP_DIVU:   ;
      OP_REM:    begin a_signed = 1'b1; b_signed = 1'b1; start_hi = 1'b1; end
      OP_REMU:   start_hi = 1'b1;
      default:   ;
    endcase
  end

  assign sa    = a_signed & a[WIDTH-1];
  assign sb    = b_signed & b[WIDTH-1];
  assign a_mag = sa ? (~a + 1'b1) : a;
  assign b_mag = sb ? (~b + 1'b1) : b;

  // One shift-add multiply step.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, m_reg} : '0);
  assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

  // One restoring-divide step; diff[WIDTH] set means the trial subtract underflowed.
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] div_next;
  assign div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, m_reg};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc_reg[WIDTH-2:0], 1'b1};

  assign done = active_reg && (cnt_reg == CW'(WIDTH));

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   part, part_fix;
  assign prod_fix = neg_reg ? (~acc_reg + 1'b1) : acc_reg;
  assign part     = hi_reg ? acc_reg[2*WIDTH-1:WIDTH] : acc_reg[WIDTH-1:0];
  assign part_fix = neg_reg ? (~part + 1'b1) : part;

  // Divide by zero: the remainder path already yields a (magnitude re-signed
  // by the dividend), only the quotient needs forcing to all ones.
  always_comb begin
    if (div_reg) begin
      result = (dz_reg && !hi_reg) ? '1 : part_fix;
    end else begin
      result = hi_reg ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg    <= '0;
      m_reg      <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
      div_reg    <= 1'b0;
      neg_reg    <= 1'b0;
      hi_reg     <= 1'b0;
      dz_reg     <= 1'b0;
    end else if (flush) begin
      active_reg <= 1'b0;
      cnt_reg    <= '0;
    end else if (start) begin
      acc_reg    <= is_divop(op) ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
      m_reg      <= is_divop(op) ? b_mag : a_mag;
      cnt_reg    <= '0;
      active_reg <= 1'b1;
      div_reg    <= is_divop(op);
      hi_reg     <= start_hi;
      // Remainder follows the dividend; quotient and products follow sa^sb.
      neg_reg    <= (is_divop(op) && start_hi) ? sa : (sa ^ sb);
      dz_reg     <= (b == '0);
    end else if (active_reg) begin
      if (done) begin
        active_reg <= 1'b0;
        cnt_reg    <= '0;
      end else begin
        acc_reg <= div_reg ? div_next : mul_next;
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential EX-stage ALU: single-cycle registered base ops plus iterative
// multiply/divide, valid/ready on both sides, flush for branch/exception.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : seq_alu_if slave (flush, in_valid/in_ready, op, a, b,
//                out_valid/out_ready, res, zero, busy)
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_alu_if.slave   bus
);
  state_t           state_reg;
  logic [WIDTH-1:0] res_reg;
  logic             out_valid_reg;
  logic             busy_reg;

  logic             accept, md_start, md_done;
  logic [WIDTH-1:0] md_result, base_res;
  logic [SHW-1:0]   shamt;

  assign bus.in_ready  = (state_reg == IDLE) & (!out_valid_reg | bus.out_ready) & !bus.flush;
  assign accept        = bus.in_valid & bus.in_ready;
  assign md_start      = accept & is_muldiv(bus.op);
  assign bus.out_valid = out_valid_reg;
  assign bus.res       = res_reg;
  assign bus.zero      = (res_reg == '0);
  assign bus.busy      = busy_reg;
  assign shamt         = bus.b[SHW-1:0];

  always_comb begin
    base_res = '0;
    case (bus.op)
      OP_AND:  base_res = bus.a & bus.b;
      OP_OR:   base_res = bus.a | bus.b;
      OP_ADD:  base_res = bus.a + bus.b;
      OP_SUB:  base_res = bus.a - bus.b;
      OP_SLT:  base_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      OP_SLTU: base_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      OP_XOR:  base_res = bus.a ^ bus.b;
      OP_SRL:  base_res = bus.a >> shamt;
      OP_SLL:  base_res = bus.a << shamt;
      OP_SRA:  base_res = $unsigned($signed(bus.a) >>> shamt);
      default: base_res = '0;   // undefined codes and the mul/div group
    endcase
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (bus.flush),
    .start  (md_start),
    .op     (bus.op),
    .a      (bus.a),
    .b      (bus.b),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      res_reg       <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else if (bus.flush) begin
      // res is left alone so the last handed-off value stays observable
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (is_muldiv(bus.op)) begin
              state_reg     <= is_divop(bus.op) ? DIV : MUL;
              busy_reg      <= 1'b1;
              out_valid_reg <= 1'b0;   // accept implies any old result was taken
            end else begin
              res_reg       <= base_res;
              out_valid_reg <= 1'b1;
            end
          end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        MUL, DIV: begin
          if (md_done) begin
            res_reg       <= md_result;
            out_valid_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic [4:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %h expected %h", name, what, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Reference: results straight from the arithmetic definitions.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, sh;
    logic [63:0] p;
    sa = a;
    sb = b;
    sh = int'(b[4:0]);
    case (op)
      OP_AND:    return a & b;
      OP_OR:     return a | b;
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU:   return (a < b) ? 32'd1 : 32'd0;
      OP_XOR:    return a ^ b;
      OP_SRL:    return a >> sh;
      OP_SLL:    return a << sh;
      OP_SRA:    return sa >>> sh;
      OP_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      OP_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      OP_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return sa / sb;
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return sa % sb;
      end
      OP_DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
      OP_REMU:   return (b == 0) ? a : a % b;
      default:   return 32'h0;
    endcase
  endfunction

  // Issue one op with out_ready=1, wait for its result, check value, latency,
  // zero flag and (for mul/div) busy/in_ready behaviour while iterating.
  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int  lat;
    int  busy_n;
    bit  ir_bad;
    bit  md;
    md     = (op[4:3] == 2'b10);
    lat    = 0;
    busy_n = 0;
    ir_bad = 1'b0;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    #1;
    chk(name, "in_ready", {31'b0, bus.in_ready}, 32'd1);
    tick;   // accept edge
    bus.in_valid = 1'b0;
    bus.a  = $urandom;   // latched at accept, so scrambling must not matter
    bus.b  = $urandom;
    bus.op = OP_ADD;
    while (!bus.out_valid && lat < 100) begin
      if (bus.busy) busy_n++;
      if (bus.in_ready) ir_bad = 1'b1;
      tick;
      lat++;
    end
    // edges after the accept edge until the result edge
    chk(name, "latency", lat, md ? (W + 1) : 0);
    chk(name, "res", bus.res, exp);
    chk(name, "zero", {31'b0, bus.zero}, {31'b0, (exp == 0)});
    if (md) begin
      chk(name, "busy_cycles", busy_n, W + 1);
      chk(name, "in_ready_while_busy", {31'b0, ir_bad}, 32'd0);
    end
    $display("%-12s op=%b a=%h b=%h res=%h exp=%h lat=%0d", name, op, a, b, bus.res, exp, lat);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [4:0] op_list [19];
  int ov_seen;

  initial begin
    op_list = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SLL, OP_SRA,
                OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, 5'b11000};

    vecs.push_back('{"add_ovf",   OP_ADD,    32'h7FFFFFFF, 32'h00000001, 32'h80000000});
    vecs.push_back('{"sub_zero",  OP_SUB,    32'h00000005, 32'h00000005, 32'h00000000});
    vecs.push_back('{"sra_big",   OP_SRA,    32'h80000000, 32'h00000024, 32'hF8000000});
    vecs.push_back('{"undef",     5'b11111,  32'h00001234, 32'h00005678, 32'h00000000});
    vecs.push_back('{"and",       OP_AND,    32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000});
    vecs.push_back('{"or",        OP_OR,     32'h0F000000, 32'h000000F0, 32'h0F0000F0});
    vecs.push_back('{"xor",       OP_XOR,    32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F});
    vecs.push_back('{"slt",       OP_SLT,    32'hFFFFFFFF, 32'h00000001, 32'h00000001});
    vecs.push_back('{"sltu",      OP_SLTU,   32'hFFFFFFFF, 32'h00000001, 32'h00000000});
    vecs.push_back('{"sll",       OP_SLL,    32'h00000001, 32'h00000021, 32'h00000002});
    vecs.push_back('{"srl",       OP_SRL,    32'h80000000, 32'h0000001F, 32'h00000001});
    vecs.push_back('{"mul_neg",   OP_MUL,    32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB});
    vecs.push_back('{"mulh_neg",  OP_MULH,   32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF});
    vecs.push_back('{"mulhsu",    OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF});
    vecs.push_back('{"mulhu_max", OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
    vecs.push_back('{"div_neg",   OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD});
    vecs.push_back('{"rem_neg",   OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF});
    vecs.push_back('{"div_nb",    OP_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD});
    vecs.push_back('{"rem_nb",    OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{"divu_z",    OP_DIVU,   32'h00000007, 32'h00000000, 32'hFFFFFFFF});
    vecs.push_back('{"remu_z",    OP_REMU,   32'h00000007, 32'h00000000, 32'h00000007});
    vecs.push_back('{"div_z_neg", OP_DIV,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF});
    vecs.push_back('{"rem_z_neg", OP_REM,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9});
    vecs.push_back('{"div_ovf",   OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000});
    vecs.push_back('{"rem_ovf",   OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000});
    vecs.push_back('{"divu",      OP_DIVU,   32'h00000064, 32'h00000007, 32'h0000000E});
    vecs.push_back('{"remu",      OP_REMU,   32'h00000064, 32'h00000007, 32'h00000002});

    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 5'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    // Reset state
    rst_n = 1'b0;
    tick;
    tick;
    chk("reset", "out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("reset", "busy", {31'b0, bus.busy}, 32'd0);
    chk("reset", "res", bus.res, 32'd0);
    chk("reset", "zero", {31'b0, bus.zero}, 32'd1);
    rst_n = 1'b1;
    tick;

    // Directed table
    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Random ops against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [4:0]  rop;
      logic [31:0] ra, rb;
      rop = op_list[$urandom_range(0, 18)];
      ra  = rnd_operand();
      rb  = rnd_operand();
      run_op("rand", rop, ra, rb, model(rop, ra, rb));
    end

    // Backpressure: hold result, then handoff with a new op on the same edge
    run_op("bp_add", OP_ADD, 32'd3, 32'd4, 32'd7);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold", "in_ready", {31'b0, bus.in_ready}, 32'd0);
      tick;
      chk("bp_hold", "out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("bp_hold", "res", bus.res, 32'd7);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = OP_ADD;
    bus.a         = 32'd10;
    bus.b         = 32'd20;
    #1;
    chk("bp_release", "in_ready", {31'b0, bus.in_ready}, 32'd1);
    tick;
    bus.in_valid = 1'b0;
    chk("bp_release", "out_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("bp_release", "res", bus.res, 32'd30);
    $display("bp_release   res=%h out_valid=%0d", bus.res, bus.out_valid);
    tick;
    chk("bp_drain", "out_valid", {31'b0, bus.out_valid}, 32'd0);

    // Flush during a divide, with an add offered on the flush cycle
    bus.op       = OP_DIV;
    bus.a        = 32'd100;
    bus.b        = 32'd7;
    bus.in_valid = 1'b1;
    #1;
    tick;
    bus.in_valid = 1'b0;
    repeat (10) tick;
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.op       = OP_ADD;
    bus.a        = 32'd5;
    bus.b        = 32'd5;
    #1;
    chk("flush", "in_ready_during", {31'b0, bus.in_ready}, 32'd0);
    tick;
    bus.flush = 1'b0;
    chk("flush", "out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("flush", "busy", {31'b0, bus.busy}, 32'd0);
    chk("flush", "res_kept", bus.res, 32'd30);
    #1;
    chk("flush", "in_ready_after", {31'b0, bus.in_ready}, 32'd1);
    bus.a = 32'd1;
    bus.b = 32'd1;
    tick;
    bus.in_valid = 1'b0;
    chk("flush_add", "out_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("flush_add", "res", bus.res, 32'd2);
    $display("flush_add    res=%h out_valid=%0d", bus.res, bus.out_valid);
    tick;
    ov_seen = 0;
    repeat (40) begin
      if (bus.out_valid) ov_seen++;
      tick;
    end
    chk("flush_quiet", "out_valid_count", ov_seen, 0);

    // Reset during a multiply
    bus.op       = OP_MUL;
    bus.a        = 32'd3;
    bus.b        = 32'd5;
    bus.in_valid = 1'b1;
    #1;
    tick;
    bus.in_valid = 1'b0;
    repeat (5) tick;
    rst_n = 1'b0;
    tick;
    chk("rst_mul", "out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_mul", "busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_mul", "res", bus.res, 32'd0);
    chk("rst_mul", "zero", {31'b0, bus.zero}, 32'd1);
    rst_n = 1'b1;
    tick;
    ov_seen = 0;
    repeat (40) begin
      if (bus.out_valid) ov_seen++;
      tick;
    end
    chk("rst_quiet", "out_valid_count", ov_seen, 0);
    $display("rst_mul      res=%h busy=%0d", bus.res, bus.busy);

    // A reset pulse between edges must not be seen
    run_op("pre_glitch", OP_ADD, 32'd2, 32'd3, 32'd5);
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick;
    chk("rst_glitch", "out_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("rst_glitch", "res", bus.res, 32'd5);
    $display("rst_glitch   res=%h out_valid=%0d", bus.res, bus.out_valid);
    bus.out_ready = 1'b1;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
